// File: rtl/regfile.sv
// 32 x 32-bit register file: one synchronous write port and two combinational read ports.
// r0 has no storage and always reads zero. All storage is cleared by an asynchronous reset.
module regfile (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  input  logic [31:0] data_writeReg,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic [DATA_W-1:0] mem [1:DEPTH-1];
  logic [DATA_W-1:0] slot [0:DEPTH-1];
  logic [DEPTH-1:1]  wr_en;
  logic [DEPTH-1:0]  sel_a;
  logic [DEPTH-1:0]  sel_b;

  // Write decode covers r1..r31 only, so a write aimed at r0 enables nothing.
  always_comb begin
    wr_en = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wr_en[i] = ctrl_writeEnable && (ctrl_writeReg == 5'(i));
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem[i] <= data_writeReg;
        end
      end
    end
  end

  // r0's slot is a constant zero, so every one-hot line gates a defined value.
  always_comb begin
    slot[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      slot[i] = mem[i];
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_a[i] = (ctrl_readRegA == 5'(i));
      sel_b[i] = (ctrl_readRegB == 5'(i));
    end
  end

  // AND-OR read mux: exactly one select is high per port.
  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      data_readRegA = data_readRegA | ({DATA_W{sel_a[i]}} & slot[i]);
      data_readRegB = data_readRegB | ({DATA_W{sel_b[i]}} & slot[i]);
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected read values, a monitor
// compares them against both read ports on each probe strobe.
module tb_regfile;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  logic  probe;
  int    checks;
  int    errors;

  logic [31:0] qa [$];
  logic [31:0] qb [$];
  string       qn [$];

  regfile dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: pop one expectation pair per probe and compare both ports.
  always @(posedge probe) begin
    logic [31:0] ea, eb;
    string nm;
    if (qa.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL probe_without_expectation A=%08h B=%08h", data_readRegA, data_readRegB);
    end else begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      nm = qn.pop_front();
      checks++;
      if (data_readRegA !== ea) begin
        errors++;
        $display("FAIL %s portA got=%08h exp=%08h", nm, data_readRegA, ea);
      end
      checks++;
      if (data_readRegB !== eb) begin
        errors++;
        $display("FAIL %s portB got=%08h exp=%08h", nm, data_readRegB, eb);
      end
    end
  end

  task automatic expect_read(input logic [4:0] a, input logic [4:0] b,
                             input logic [31:0] ea, input logic [31:0] eb,
                             input string nm);
    ctrl_readRegA = a;
    ctrl_readRegB = b;
    #1;
    qa.push_back(ea);
    qb.push_back(eb);
    qn.push_back(nm);
    probe = 1'b1;
    #1;
    probe = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = r;
    data_writeReg    = d;
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int n);
    return (n == 0) ? 32'h0 : 32'h1000_0000 + 32'(n);
  endfunction

  initial begin
    probe            = 1'b0;
    checks           = 0;
    errors           = 0;
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    data_writeReg    = '0;

    // Reset sweep with a write attempt held active during reset.
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'h9999_9999;
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    for (int i = 0; i < 32; i++)
      expect_read(5'(i), 5'(31 - i), 32'h0, 32'h0, "reset_sweep");
    @(negedge clock);
    ctrl_reset = 1'b0;

    // Write r1..r31 on consecutive edges, then read all pairs.
    @(negedge clock);
    for (int n = 1; n < 32; n++) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'(n);
      data_writeReg    = pat(n);
      @(negedge clock);
    end
    ctrl_writeEnable = 1'b0;
    for (int n = 0; n < 32; n++)
      expect_read(5'(n), 5'(31 - n), pat(n), pat(31 - n), "write_readback");

    // r0 immunity.
    write_reg(5'd0, 32'hDEAD_BEEF);
    expect_read(5'd0, 5'd0, 32'h0, 32'h0, "r0_immunity");
    for (int n = 1; n < 32; n++)
      expect_read(5'(n), 5'(32 - n), pat(n), pat(32 - n), "r0_no_side_effect");

    // Enable gating.
    write_reg(5'd5, 32'h1234_5678);
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd5;
    data_writeReg    = 32'hFFFF_FFFF;
    repeat (3) @(posedge clock);
    #1;
    expect_read(5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678, "enable_gating");
    expect_read(5'd4, 5'd6, pat(4), pat(6), "enable_gating_neighbours");

    // Same-cycle read and write of r7.
    write_reg(5'd7, 32'hAAAA_5555);
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'h0F0F_0F0F;
    expect_read(5'd7, 5'd7, 32'hAAAA_5555, 32'hAAAA_5555, "same_cycle_before");
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    expect_read(5'd7, 5'd7, 32'h0F0F_0F0F, 32'h0F0F_0F0F, "same_cycle_after");

    // Async reset mid-run, with a write presented on an edge during reset.
    write_reg(5'd3, 32'hCAFE_F00D);
    expect_read(5'd3, 5'd31, 32'hCAFE_F00D, pat(31), "pre_async_reset");
    @(negedge clock);
    #1;
    ctrl_reset = 1'b1;
    expect_read(5'd3, 5'd31, 32'h0, 32'h0, "async_reset_immediate");
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'h1111_1111;
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    expect_read(5'd3, 5'd7, 32'h0, 32'h0, "write_during_reset_ignored");
    #2;
    ctrl_reset = 1'b0;
    expect_read(5'd3, 5'd5, 32'h0, 32'h0, "after_reset_release");

    // First write after release lands on the next edge.
    write_reg(5'd3, 32'h0000_0055);
    expect_read(5'd3, 5'd0, 32'h0000_0055, 32'h0, "first_write_after_reset");

    #5;
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", qa.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
